// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM states and MIPS opcode/funct constants shared with decode
package instr_fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, VALID} state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
endpackage

// File: rtl/instr_split.sv
// instr_split: combinational split of a 32-bit MIPS word into its fields
module instr_split (
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm_o
);
  assign opcode_o = instr_i[31:26];
  assign rs_o     = instr_i[25:21];
  assign rt_o     = instr_i[20:16];
  assign rd_o     = instr_i[15:11];
  assign funct_o  = instr_i[5:0];
  assign imm_o    = instr_i[15:0];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + imem req/ack fetch, IR presented via valid/ready, branch redirect with drain
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, redir_q, redir_d, ir_q, ir_d, pc4_q, pc4_d, cnt_q, cnt_d;
  logic [31:0] tgt;
  assign tgt = branch_target & ~32'h3;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redir_d = redir_q;
    ir_d = ir_q;
    pc4_d = pc4_q;
    cnt_d = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
        pc_d = branch_taken ? tgt : pc_q;
      end
      FETCH:
        if (branch_taken) begin
          pc_d = imem_ack ? tgt : pc_q;
          redir_d = tgt;
          state_d = imem_ack ? FETCH : DRAIN;
        end else if (imem_ack) begin
          ir_d = imem_rdata;
          pc_d = pc_q + 32'd4;
          pc4_d = pc_q + 32'd4;
          state_d = VALID;
        end
      DRAIN: begin
        // the address must not move until the old request is acked; latest target wins
        redir_d = branch_taken ? tgt : redir_q;
        pc_d = imem_ack ? redir_d : pc_q;
        state_d = imem_ack ? FETCH : DRAIN;
      end
      default:
        if (branch_taken) begin
          pc_d = tgt;
          state_d = FETCH;
        end else if (out_ready) begin
          cnt_d = cnt_q + 32'd1;
          state_d = FETCH;
        end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      redir_q <= RESET_PC;
      ir_q <= '0;
      pc4_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redir_q <= redir_d;
      ir_q <= ir_d;
      pc4_q <= pc4_d;
      cnt_q <= cnt_d;
    end
  assign imem_req = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr = pc_q;
  assign out_valid = state_q == VALID;
  assign pc_plus4 = pc4_q;
  assign instr_count = cnt_q;
  instr_split u_split (
    .instr_i (ir_q),
    .opcode_o(opcode),
    .rs_o    (rs),
    .rt_o    (rt),
    .rd_o    (rd),
    .funct_o (funct),
    .imm_o   (imm)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run against a behavioural fetch model
module tb_instr_fetch;
  import instr_fetch_pkg::*;
  logic clk = 0, reset = 1, imem_ack = 0, branch_taken = 0, out_ready = 0;
  logic [31:0] imem_rdata = 0, branch_target = 0;
  logic imem_req, out_valid;
  logic [31:0] imem_addr, pc_plus4, instr_count;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc_plus4(pc_plus4), .instr_count(instr_count)
  );
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0] op, fn;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    op = h[2:0] == 0 ? OP_RTYPE : h[2:0] == 1 ? OP_ADDI : h[2:0] == 2 ? OP_LW :
         h[2:0] == 3 ? OP_SW : h[2:0] == 4 ? OP_BEQ : h[31:26];
    fn = h[5:3] == 0 ? F_ADD : h[5:3] == 1 ? F_SUB : h[5:3] == 2 ? F_AND :
         h[5:3] == 3 ? F_OR : h[5:3] == 4 ? F_SLT : h[11:6];
    return {op, h[25:6], fn};
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1; imem_ack = 0; branch_taken = 0; out_ready = 0;
    cyc;
    reset = 0;
  endtask
  task automatic test_reset;
    logic [150:0] got;
    reset = 1;
    #3;
    got = {imem_req, imem_addr, out_valid, opcode, funct, rs, rt, rd, imm, pc_plus4, instr_count};
    total++; if (got !== '0) begin bad++; $display("FAIL reset_async got %h want 0", got); end
    cyc;
    got = {imem_req, imem_addr, out_valid, opcode, funct, rs, rt, rd, imm, pc_plus4, instr_count};
    total++; if (got !== '0) begin bad++; $display("FAIL reset_held got %h want 0", got); end
    reset = 0;
  endtask
  task automatic test_zero_wait;
    imem_ack = 1; imem_rdata = {OP_RTYPE, 20'h0, F_ADD}; out_ready = 1;
    cyc;
    total++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
      bad++; $display("FAIL zw_req0 got %b %h %b want 1 0 0", imem_req, imem_addr, out_valid); end
    cyc;
    total++; if ({out_valid, imem_req, opcode, funct, pc_plus4} !== {1'b1, 1'b0, 6'h00, 6'h20, 32'h4}) begin
      bad++; $display("FAIL zw_valid got v=%b req=%b op=%h fn=%h pc4=%h", out_valid, imem_req, opcode, funct, pc_plus4); end
    cyc;
    total++; if ({imem_req, imem_addr, out_valid, instr_count} !== {1'b1, 32'h4, 1'b0, 32'd1}) begin
      bad++; $display("FAIL zw_req4 got %b %h %b cnt=%0d want 1 4 0 cnt=1", imem_req, imem_addr, out_valid, instr_count); end
    imem_ack = 0; out_ready = 0;
  endtask
  task automatic test_delayed_ack;
    do_reset;
    imem_rdata = {OP_LW, 5'd1, 5'd2, 16'd4};
    for (int i = 0; i < 4; i++) begin
      cyc;
      total++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
        bad++; $display("FAIL dly_hold%0d got %b %h %b want 1 0 0", i, imem_req, imem_addr, out_valid); end
      if (i == 3) imem_ack = 1;
    end
    cyc;
    imem_ack = 0;
    total++; if ({out_valid, opcode, rs, rt, imm, pc_plus4} !== {1'b1, 6'h23, 5'd1, 5'd2, 16'h4, 32'h4}) begin
      bad++; $display("FAIL dly_fields got v=%b op=%h rs=%0d rt=%0d imm=%h pc4=%h", out_valid, opcode, rs, rt, imm, pc_plus4); end
  endtask
  task automatic test_stall;
    for (int i = 0; i < 5; i++) begin
      cyc;
      total++; if ({out_valid, imem_req, opcode, rs, rt, imm, pc_plus4, instr_count} !==
                   {1'b1, 1'b0, 6'h23, 5'd1, 5'd2, 16'h4, 32'h4, 32'd0}) begin
        bad++; $display("FAIL stall%0d got v=%b req=%b op=%h imm=%h cnt=%0d", i, out_valid, imem_req, opcode, imm, instr_count); end
    end
    out_ready = 1;
    cyc;
    out_ready = 0;
    total++; if ({out_valid, imem_req, imem_addr, instr_count} !== {1'b0, 1'b1, 32'h4, 32'd1}) begin
      bad++; $display("FAIL stall_xfer got v=%b req=%b addr=%h cnt=%0d", out_valid, imem_req, imem_addr, instr_count); end
  endtask
  task automatic test_drain;
    branch_target = 32'h40; branch_taken = 1;
    cyc;
    branch_taken = 0;
    total++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h4, 1'b0}) begin
      bad++; $display("FAIL drain_a got %b %h %b want 1 4 0", imem_req, imem_addr, out_valid); end
    branch_target = 32'h80; branch_taken = 1;
    cyc;
    branch_taken = 0;
    total++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'h4, 1'b0}) begin
      bad++; $display("FAIL drain_b got %b %h %b want 1 4 0", imem_req, imem_addr, out_valid); end
    imem_rdata = 32'hDEAD_BEEF; imem_ack = 1;
    cyc;
    imem_ack = 0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({imem_req, imem_addr, out_valid, instr_count} !== {1'b1, 32'h80, 1'b0, 32'd1}) begin
        bad++; $display("FAIL drain_redir%0d got %b %h %b cnt=%0d want 1 80 0 1", i, imem_req, imem_addr, out_valid, instr_count); end
      cyc;
    end
  endtask
  task automatic test_branch_valid;
    imem_rdata = {OP_ADDI, 5'd3, 5'd4, 16'hBEEF}; imem_ack = 1;
    cyc;
    imem_ack = 0;
    total++; if ({out_valid, opcode, imm, pc_plus4} !== {1'b1, 6'h08, 16'hBEEF, 32'h84}) begin
      bad++; $display("FAIL bv_fields got v=%b op=%h imm=%h pc4=%h", out_valid, opcode, imm, pc_plus4); end
    branch_target = 32'h103; branch_taken = 1; out_ready = 1;
    cyc;
    branch_taken = 0; out_ready = 0;
    total++; if ({out_valid, imem_req, imem_addr, instr_count} !== {1'b0, 1'b1, 32'h100, 32'd1}) begin
      bad++; $display("FAIL bv_redir got v=%b req=%b addr=%h cnt=%0d", out_valid, imem_req, imem_addr, instr_count); end
  endtask
  task automatic test_wrap;
    branch_target = 32'hFFFF_FFFC; branch_taken = 1; imem_ack = 1; imem_rdata = 32'h1234_5678;
    cyc;
    branch_taken = 0;
    total++; if ({imem_req, imem_addr, out_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      bad++; $display("FAIL wrap_req got %b %h %b", imem_req, imem_addr, out_valid); end
    cyc;
    imem_ack = 0;
    total++; if ({out_valid, pc_plus4} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL wrap_pc4 got v=%b pc4=%h want 1 0", out_valid, pc_plus4); end
    out_ready = 1;
    cyc;
    out_ready = 0;
    total++; if ({imem_req, imem_addr, instr_count} !== {1'b1, 32'h0, 32'd2}) begin
      bad++; $display("FAIL wrap_next got %b %h cnt=%0d want 1 0 2", imem_req, imem_addr, instr_count); end
  endtask
  task automatic test_reset_mid_drain;
    logic [150:0] got;
    branch_target = 32'h200; branch_taken = 1;
    cyc;
    branch_taken = 0;
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL rst_drain_pre got %b %h want 1 0", imem_req, imem_addr); end
    #2 reset = 1;
    #1;
    got = {imem_req, imem_addr, out_valid, opcode, funct, rs, rt, rd, imm, pc_plus4, instr_count};
    total++; if (got !== '0) begin bad++; $display("FAIL rst_drain_now got %h want 0", got); end
    #2 reset = 0;
    cyc;
    total++; if ({imem_req, imem_addr, out_valid, instr_count} !== {1'b1, 32'h0, 1'b0, 32'd0}) begin
      bad++; $display("FAIL rst_drain_resume got %b %h %b cnt=%0d", imem_req, imem_addr, out_valid, instr_count); end
  endtask
  task automatic test_random;
    int mode;
    logic [31:0] pc, redir, ir, pc4, cnt, t;
    do_reset;
    mode = 0; pc = 0; redir = 0; ir = 0; pc4 = 0; cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      imem_ack = (mode == 1 || mode == 2) && $urandom_range(2) == 0;
      imem_rdata = imem_ack ? word_at(pc) : $urandom;
      branch_taken = $urandom_range(7) == 0;
      branch_target = $urandom_range(3) == 0 ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      out_ready = $urandom_range(1) == 1;
      t = {branch_target[31:2], 2'b00};
      if (mode == 0) begin
        if (branch_taken) pc = t;
        mode = 1;
      end else if (mode == 1) begin
        if (branch_taken && imem_ack) pc = t;
        else if (branch_taken) begin redir = t; mode = 2; end
        else if (imem_ack) begin ir = imem_rdata; pc = pc + 4; pc4 = pc; mode = 3; end
      end else if (mode == 2) begin
        if (branch_taken) redir = t;
        if (imem_ack) begin pc = redir; mode = 1; end
      end else begin
        if (branch_taken) begin pc = t; mode = 1; end
        else if (out_ready) begin cnt++; mode = 1; end
      end
      cyc;
      total++; if ({imem_req, imem_addr, out_valid, instr_count} !== {mode == 1 || mode == 2, pc, mode == 3, cnt}) begin
        bad++; $display("FAIL rnd_ctl%0d got req=%b addr=%h v=%b cnt=%0d want mode=%0d addr=%h cnt=%0d",
                        n, imem_req, imem_addr, out_valid, instr_count, mode, pc, cnt); end
      if (mode == 3) begin
        total++; if ({opcode, rs, rt, rd, funct, imm, pc_plus4} !== {ir[31:26], ir[25:21], ir[20:16], ir[15:11], ir[5:0], ir[15:0], pc4}) begin
          bad++; $display("FAIL rnd_fields%0d got op=%h rs=%0d rt=%0d rd=%0d fn=%h imm=%h pc4=%h want ir=%h pc4=%h",
                          n, opcode, rs, rt, rd, funct, imm, pc_plus4, ir, pc4); end
      end
    end
    imem_ack = 0; branch_taken = 0; out_ready = 0;
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_delayed_ack;
    test_stall;
    test_drain;
    test_branch_valid;
    test_wrap;
    test_reset_mid_drain;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the MIPS core: holds the PC, requests words from instruction memory over a req/ack handshake, and presents the split instruction fields (opcode, funct, rs, rt, rd, imm) to the control unit and register file through a valid/ready handshake. It is the producer side of the opcode/funct interface the control unit consumes. It also accepts branch redirects from execute and discards in-flight or buffered instructions on a taken branch.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, held high until imem_ack
- imem_addr  out  32  word-aligned fetch address, stable while imem_req high
- imem_ack  in  1  memory response strobe; may arrive in the same cycle as imem_req (zero wait)
- imem_rdata  in  32  instruction word, valid when imem_ack high
- branch_taken  in  1  one-cycle redirect pulse from execute
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 00)
- out_valid  out  1  instruction fields valid
- out_ready  in  1  decode accepts fields
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm  out  16  instr[15:0]
- pc_plus4  out  32  address of the presented instruction + 4
- instr_count  out  32  number of completed out_valid/out_ready transfers, wraps at 2^32

## Operation
- States: BOOT, FETCH, DRAIN, VALID.
- BOOT: entered on reset; imem_req=0; unconditionally -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata into IR, pc_plus4<=pc+4, pc<=pc+4, -> VALID.
- VALID: out_valid=1, fields driven from IR, held stable while out_ready=0. On out_valid&out_ready: instr_count+1, -> FETCH.
- Redirect (branch_taken=1), priority over all other events in the same cycle:
  - FETCH with imem_ack same cycle: discard rdata, pc<=target, stay FETCH.
  - FETCH without imem_ack: store target in redirect reg, -> DRAIN (imem_addr must not change mid-request).
  - DRAIN: imem_req stays 1 on old address; a further branch_taken overwrites redirect reg (latest wins); on imem_ack discard rdata, pc<=redirect reg, -> FETCH.
  - VALID: out_valid cleared next cycle, IR contents dropped, pc<=target, -> FETCH; a simultaneous out_ready is not a transfer (instr_count unchanged).
  - BOOT: pc<=target, -> FETCH.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Reset mid-operation: all state to reset values immediately; memory shares reset and drops pending requests, so no stale ack is expected.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, opcode/funct/rs/rt/rd/imm=0, pc_plus4=0, instr_count=0, state=BOOT.
- All outputs registered or decoded from registered state only; no combinational path from imem_ack/out_ready/branch_taken to any output.
- Zero-wait memory, out_ready=1: req at cycle n, out_valid at n+1, next req at n+2 -> throughput 1 instruction / 2 cycles.
- First request: cycle 1 after reset deassertion.
- Redirect latency: target appears on imem_addr the cycle after branch_taken (FETCH-with-ack, VALID, BOOT) or the cycle after the draining ack (DRAIN).

## Structure
- Shared definitions file mips_defs.v: opcode constants OP_RTYPE 6'b000000, OP_ADDI 6'b001000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100; funct constants ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010; state encodings of this block.
- One sub-module: instr_split, purely combinational 32-bit word -> opcode/rs/rt/rd/funct/imm; reused by decode.

## Test plan
- Reset, RESET_PC=0, zero-wait memory returning 32'h0000_0020 (add), out_ready=1 -> req at cycle 1 addr 0; cycle 2 out_valid=1, opcode=000000, funct=100000, pc_plus4=4; cycle 3 req addr 4.
- Memory ack delayed 3 cycles, word 32'h8C22_0004 (lw) -> imem_addr stays 0 all 4 cycles; then opcode=100011, rs=1, rt=2, imm=4.
- out_ready low 5 cycles in VALID -> all fields and out_valid stable, no new req, instr_count unchanged until transfer, then +1.
- branch_taken target 32'h40 during a pending request (DRAIN), second pulse target 32'h80 before ack -> ack data discarded, out_valid never high for it, next req addr 32'h80.
- branch_taken target 32'h103 while VALID with out_ready=1 -> no transfer, instr_count unchanged, next req addr 32'h100.
- PC at 32'hFFFF_FFFC fetched -> pc_plus4=0, next req addr 0; reset asserted mid-DRAIN -> outputs at reset values same cycle, req resumes at RESET_PC.
